// File: rtl/trng_pkg.sv
// Shared types and constants for the ring-oscillator byte reader.
package trng_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2,
        FAIL = 2'd3
    } trng_state_e;

    localparam int DEFAULT_REP_LIMIT = 32;
    localparam int BYTE_W            = 8;

endpackage

// File: rtl/trng_rep_counter.sv
// Repetition-count health test: tracks the run length of identical sampled
// bits and pulses trip on the sample that makes the run reach REP_LIMIT.
module trng_rep_counter
    import trng_pkg::*;
#(
    parameter int REP_LIMIT = DEFAULT_REP_LIMIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic sample,
    input  logic bit_in,
    output logic trip
);

    localparam int CNT_W = $clog2(REP_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(REP_LIMIT);

    logic [CNT_W-1:0] run_cnt_q, run_cnt_d, run_next;
    logic             prev_q, prev_d;

    // A zero count means no previous bit is known, so the run starts fresh.
    always_comb begin
        run_next  = (run_cnt_q == '0 || bit_in != prev_q) ? CNT_W'(1)
                                                          : run_cnt_q + CNT_W'(1);
        run_cnt_d = run_cnt_q;
        prev_d    = prev_q;
        if (sample) begin
            run_cnt_d = run_next;
            prev_d    = bit_in;
        end
        if (clear) begin
            run_cnt_d = '0;
            prev_d    = 1'b0;
        end
        trip = sample && (run_next == LIMIT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_cnt_q <= '0;
            prev_q    <= 1'b0;
        end else begin
            run_cnt_q <= run_cnt_d;
            prev_q    <= prev_d;
        end
    end

endmodule

// File: rtl/trng_byte_reader.sv
// Samples the RO bit stream, health-tests it and packs accepted bits MSB-first
// into bytes on a valid/ready port. TRNG_VN_DEBIAS_EN enables von Neumann debias.
module trng_byte_reader
    import trng_pkg::*;
#(
    parameter int REP_LIMIT = DEFAULT_REP_LIMIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              raw_bit,
    input  logic              sample_stb,
    output logic [BYTE_W-1:0] byte_out,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              health_fail
);

    localparam logic [3:0] LAST_BIT = 4'(BYTE_W - 1);
    localparam logic [3:0] FULL_CNT = 4'(BYTE_W);

    trng_state_e       state_q, state_d;
    logic              sync_meta_q, sync_q;
    logic [BYTE_W-1:0] shift_q, shift_d, out_q, out_d, new_byte;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic              valid_q, valid_d, fail_q, fail_d;
    logic              sample, accept, acc_bit, byte_done, handoff, out_free, trip;

    assign sample    = sample_stb && en && (state_q == FILL || state_q == FULL);
    assign handoff   = valid_q && byte_ready;
    assign out_free  = !valid_q || handoff;
    assign byte_done = accept && (bit_cnt_q == LAST_BIT);
    assign new_byte  = {shift_q[BYTE_W-2:0], acc_bit};

    trng_rep_counter #(.REP_LIMIT(REP_LIMIT)) u_rep (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (!en),
        .sample (sample),
        .bit_in (sync_q),
        .trip   (trip)
    );

`ifdef TRNG_VN_DEBIAS_EN
    logic pair_have_q, pair_have_d, pair_bit_q, pair_bit_d;

    // Non-overlapping pairs; an unequal pair yields its first bit.
    always_comb begin
        pair_have_d = pair_have_q;
        pair_bit_d  = pair_bit_q;
        accept      = 1'b0;
        acc_bit     = pair_bit_q;
        if (sample) begin
            if (!pair_have_q) begin
                pair_have_d = 1'b1;
                pair_bit_d  = sync_q;
            end else begin
                pair_have_d = 1'b0;
                accept      = (state_q == FILL) && (sync_q != pair_bit_q);
            end
        end
        if (!en) begin
            pair_have_d = 1'b0;
            pair_bit_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pair_have_q <= 1'b0;
            pair_bit_q  <= 1'b0;
        end else begin
            pair_have_q <= pair_have_d;
            pair_bit_q  <= pair_bit_d;
        end
    end
`else
    always_comb begin
        accept  = sample && (state_q == FILL);
        acc_bit = sync_q;
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (en) state_d = FILL;
            FILL: begin
                if (!en)                          state_d = IDLE;
                else if (byte_done && !out_free)  state_d = FULL;
            end
            FULL: begin
                if (!en)          state_d = IDLE;
                else if (handoff) state_d = FILL;
            end
            FAIL: state_d = FAIL;
        endcase
        if (trip) state_d = FAIL;
    end

    // A completed byte waits in shift_q (FULL) while the output is occupied.
    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        out_d     = out_q;
        valid_d   = valid_q && !handoff;
        fail_d    = fail_q || trip;
        if (accept) begin
            if (byte_done && out_free) begin
                out_d     = new_byte;
                valid_d   = 1'b1;
                shift_d   = '0;
                bit_cnt_d = '0;
            end else if (byte_done) begin
                shift_d   = new_byte;
                bit_cnt_d = FULL_CNT;
            end else begin
                shift_d   = new_byte;
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end
        if (state_q == FULL && handoff && en) begin
            out_d     = shift_q;
            valid_d   = 1'b1;
            shift_d   = '0;
            bit_cnt_d = '0;
        end
        if (!en) begin
            shift_d   = '0;
            bit_cnt_d = '0;
        end
        if (trip) begin
            valid_d   = 1'b0;
            shift_d   = '0;
            bit_cnt_d = '0;
        end
    end

    always_comb begin
        byte_out    = out_q;
        byte_valid  = valid_q;
        health_fail = fail_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sync_meta_q <= 1'b0;
            sync_q      <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            out_q       <= '0;
            valid_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_meta_q <= raw_bit;
            sync_q      <= sync_meta_q;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            out_q       <= out_d;
            valid_q     <= valid_d;
            fail_q      <= fail_d;
        end
    end

endmodule

// File: tb/tb_trng_byte_reader.sv
// Bench for trng_byte_reader: a default-limit DUT and a REP_LIMIT=4 DUT share stimulus.
module tb_trng_byte_reader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic raw_bit = 1'b0;
  logic sample_stb = 1'b0;
  logic byte_ready = 1'b0;
  logic [7:0] byte_out_a, byte_out_b;
  logic valid_a, valid_b, fail_a, fail_b;

  always #5 clk = ~clk;

  trng_byte_reader dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .raw_bit(raw_bit), .sample_stb(sample_stb),
    .byte_out(byte_out_a), .byte_valid(valid_a), .byte_ready(byte_ready),
    .health_fail(fail_a)
  );

  trng_byte_reader #(.REP_LIMIT(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .raw_bit(raw_bit), .sample_stb(sample_stb),
    .byte_out(byte_out_b), .byte_valid(valid_b), .byte_ready(byte_ready),
    .health_fail(fail_b)
  );

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: output side is a byte queue of depth two (output register
  // plus one completed byte waiting); collection stalls while two are queued.
  typedef struct {
    bit       s1, s2;
    bit       active, failed;
    int       run;
    bit       prev;
    int       pcnt;
    bit [7:0] pval;
    bit       ph, pb;
    int       on;
    bit [7:0] ob0, ob1;
  } mdl_t;

  function automatic mdl_t step(mdl_t m, bit rst_i, bit en_i, bit raw_i, bit stb_i,
                                bit rdy_i, int limit);
    mdl_t n;
    bit smp, acc, abit;
    n = m;
    if (!rst_i) begin
      n = '{default: 0};
      return n;
    end
    smp = m.s2;
    n.s2 = m.s1;
    n.s1 = raw_i;
    if (m.failed) return n;
    if (!en_i && n.on == 2) n.on = 1;
    if (rdy_i && m.on > 0) begin
      n.ob0 = n.ob1;
      n.on = n.on - 1;
    end
    if (m.active && en_i && stb_i) begin
      n.run = (m.run > 0 && smp == m.prev) ? m.run + 1 : 1;
      n.prev = smp;
      abit = smp;
`ifdef TRNG_VN_DEBIAS_EN
      acc = 1'b0;
      if (!m.ph) begin
        n.ph = 1'b1;
        n.pb = smp;
      end else begin
        n.ph = 1'b0;
        acc = (smp != m.pb);
        abit = m.pb;
      end
`else
      acc = 1'b1;
`endif
      if (acc && m.on < 2) begin
        n.pval = {m.pval[6:0], abit};
        n.pcnt = m.pcnt + 1;
        if (n.pcnt == 8) begin
          if (n.on == 0) n.ob0 = n.pval;
          else n.ob1 = n.pval;
          n.on = n.on + 1;
          n.pcnt = 0;
          n.pval = '0;
        end
      end
      if (n.run == limit) begin
        n.failed = 1'b1;
        n.on = 0;
        n.pcnt = 0;
        n.pval = '0;
      end
    end
    if (!en_i) begin
      n.run = 0;
      n.prev = 1'b0;
      n.pcnt = 0;
      n.pval = '0;
      n.ph = 1'b0;
      n.pb = 1'b0;
    end
    n.active = en_i && !n.failed;
    return n;
  endfunction

  mdl_t ma, mb;
  bit mdl_on = 1'b0;

  always @(posedge clk) begin
    cyc++;
    ma = step(ma, rst_n, en, raw_bit, sample_stb, byte_ready, 32);
    mb = step(mb, rst_n, en, raw_bit, sample_stb, byte_ready, 4);
  end

  always @(negedge clk) begin
    if (mdl_on) begin
      chk("mdl_a_valid", 32'(valid_a), 32'(ma.on > 0));
      if (ma.on > 0) chk("mdl_a_byte", 32'(byte_out_a), 32'(ma.ob0));
      chk("mdl_a_fail", 32'(fail_a), 32'(ma.failed));
      chk("mdl_b_valid", 32'(valid_b), 32'(mb.on > 0));
      if (mb.on > 0) chk("mdl_b_byte", 32'(byte_out_b), 32'(mb.ob0));
      chk("mdl_b_fail", 32'(fail_b), 32'(mb.failed));
    end
  end

  // Scoreboard: bytes handed off by each DUT against the expected queue.
  logic [7:0] exp_q[$];
  logic [7:0] got_a[$], got_b[$];
  int got_ta[$];

  always @(negedge clk) begin
    if (rst_n && byte_ready) begin
      if (valid_a) begin
        got_a.push_back(byte_out_a);
        got_ta.push_back(cyc);
      end
      if (valid_b) got_b.push_back(byte_out_b);
    end
  end

  task automatic clear_q();
    exp_q.delete();
    got_a.delete();
    got_b.delete();
    got_ta.delete();
  endtask

  task automatic drain(input string name, input bit use_b);
    chk({name, "_cnt_a"}, 32'(got_a.size()), 32'(exp_q.size()));
    if (use_b) chk({name, "_cnt_b"}, 32'(got_b.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (i < got_a.size()) chk({name, "_a"}, 32'(got_a[i]), 32'(exp_q[i]));
      if (use_b && i < got_b.size()) chk({name, "_b"}, 32'(got_b[i]), 32'(exp_q[i]));
    end
    clear_q();
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raw level is held for two edges so the synchronizer output equals b
  // on the strobe edge.
  task automatic send_bit(input bit b);
    raw_bit = b;
    sample_stb = 1'b0;
    tick(2);
    sample_stb = 1'b1;
    tick(1);
    sample_stb = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    clear_q();
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_byte_a"}, 32'(byte_out_a), 32'h00);
    chk({name, "_valid_a"}, 32'(valid_a), 32'd0);
    chk({name, "_fail_a"}, 32'(fail_a), 32'd0);
    chk({name, "_byte_b"}, 32'(byte_out_b), 32'h00);
    chk({name, "_valid_b"}, 32'(valid_b), 32'd0);
    chk({name, "_fail_b"}, 32'(fail_b), 32'd0);
  endtask

  typedef struct {
    logic [7:0] bits;
    logic [7:0] exp_byte;
    bit         b_trips;
  } vec_t;

  vec_t vecs[5];
  logic [19:0] raw20;
  logic [3:0] hbits;
  bit stuck_val;

  initial begin
    vecs[0] = '{8'b1011_0010, 8'hB2, 1'b0};
    vecs[1] = '{8'b0101_0101, 8'h55, 1'b0};
    vecs[2] = '{8'b1100_1100, 8'hCC, 1'b0};
    vecs[3] = '{8'b1001_1010, 8'h9A, 1'b0};
    vecs[4] = '{8'b0000_1111, 8'h0F, 1'b1};

    tick(2);
    rst_n = 1'b1;
    mdl_on = 1'b1;
    @(negedge clk);
    chk_zero("reset");
    tick(1);

`ifdef TRNG_VN_DEBIAS_EN
    en = 1'b1;
    byte_ready = 1'b1;
    tick(1);
    raw20 = 20'b01_00_10_11_10_10_01_01_10_01;
    for (int i = 19; i >= 0; i--) send_bit(raw20[i]);
    tick(3);
    exp_q.push_back(8'h72);
    drain("debias", 1'b1);
    do_reset();
`else
    en = 1'b1;
    byte_ready = 1'b1;
    tick(1);
    for (int i = 0; i < 5; i++) begin
      clear_q();
      send_byte(vecs[i].bits);
      tick(3);
      exp_q.push_back(vecs[i].exp_byte);
      chk("vec_fail_a", 32'(fail_a), 32'd0);
      chk("vec_fail_b", 32'(fail_b), 32'(vecs[i].b_trips));
      if (vecs[i].b_trips) chk("vec_none_b", 32'(got_b.size()), 32'd0);
      drain("vec", !vecs[i].b_trips);
    end
    do_reset();
`endif

    // Health trip on the REP_LIMIT-th identical bit, then terminal.
    en = 1'b1;
    byte_ready = 1'b1;
    tick(1);
    hbits = 4'b0111;
    for (int i = 3; i >= 0; i--) send_bit(hbits[i]);
    @(negedge clk);
    chk("hlth_pre_b", 32'(fail_b), 32'd0);
    tick(1);
    send_bit(1'b1);
    @(negedge clk);
    chk("hlth_trip_b", 32'(fail_b), 32'd1);
    chk("hlth_valid_b", 32'(valid_b), 32'd0);
    chk("hlth_a_ok", 32'(fail_a), 32'd0);
    tick(1);
    clear_q();
    for (int i = 0; i < 8; i++) send_bit(i[0]);
    tick(2);
    @(negedge clk);
    chk("hlth_sticky_b", 32'(fail_b), 32'd1);
    chk("hlth_ignored_b", 32'(got_b.size()), 32'd0);
    tick(1);
    do_reset();
    @(negedge clk);
    chk("hlth_reset_b", 32'(fail_b), 32'd0);
    tick(1);

`ifndef TRNG_VN_DEBIAS_EN
    // Backpressure: first byte held, second waits, third dropped.
    do_reset();
    en = 1'b1;
    byte_ready = 1'b0;
    tick(1);
    send_byte(8'hA5);
    @(negedge clk);
    chk("bp_hold1_a", 32'(byte_out_a), 32'hA5);
    tick(1);
    send_byte(8'h5A);
    send_byte(8'h96);
    @(negedge clk);
    chk("bp_hold3_a", 32'(byte_out_a), 32'hA5);
    chk("bp_valid_a", 32'(valid_a), 32'd1);
    chk("bp_hold3_b", 32'(byte_out_b), 32'hA5);
    tick(1);
    byte_ready = 1'b1;
    tick(4);
    chk("bp_consec", (got_ta.size() >= 2) ? 32'(got_ta[1] - got_ta[0]) : 32'hFFFF_FFFF, 32'd1);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    drain("bp", 1'b1);

    // Reset in the middle of a byte with one byte pending.
    do_reset();
    en = 1'b1;
    byte_ready = 1'b0;
    tick(1);
    send_byte(8'h5A);
    for (int i = 0; i < 5; i++) send_bit(i[0] ^ (i < 2));
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("midrst");
    tick(1);
    clear_q();
    byte_ready = 1'b1;
    send_byte(8'h69);
    tick(3);
    exp_q.push_back(8'h69);
    drain("midrst", 1'b1);

    // en=0 with a pending byte and three partial bits.
    do_reset();
    en = 1'b1;
    byte_ready = 1'b0;
    tick(1);
    send_byte(8'h5A);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    en = 1'b0;
    tick(3);
    @(negedge clk);
    chk("en0_valid_a", 32'(valid_a), 32'd1);
    chk("en0_byte_a", 32'(byte_out_a), 32'h5A);
    tick(1);
    en = 1'b1;
    byte_ready = 1'b1;
    tick(1);
    send_byte(8'hD2);
    tick(3);
    chk("en0_fail_b", 32'(fail_b), 32'd0);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hD2);
    drain("en0", 1'b1);
`endif

    // Randomized traffic; periodic stuck-at stretches exercise the health test.
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      if (k % 600 == 0) stuck_val = 1'($urandom_range(0, 1));
      raw_bit = (k % 600 < 150) ? stuck_val : 1'($urandom_range(0, 1));
      sample_stb = ($urandom_range(0, 9) < 6);
      byte_ready = ($urandom_range(0, 9) < 7);
      if (en) en = ($urandom_range(0, 99) >= 2);
      else en = ($urandom_range(0, 99) < 25);
      rst_n = (k % 600 == 599) ? 1'b0 : ($urandom_range(0, 499) != 0);
      tick(1);
    end
    rst_n = 1'b1;
    sample_stb = 1'b0;
    tick(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
